// File: rtl/sar_pkg.sv
// Shared defaults and state encoding for the SAR capture/averaging block.
// No logic; constants and types only.
// Backpressure: not applicable.
package sar_pkg;

    localparam int SAR_WIDTH_DEF  = 10;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

    // Number of samples in a window selected by a 2-bit code (1/2/4/8).
    function automatic logic [3:0] win_len(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Single-clock FIFO with a registered head output and sticky overflow flag.
// Latency: a write is visible on rd_vld_o the cycle after it is accepted.
// Backpressure: a write into a full FIFO is dropped unless a pop frees a slot that cycle.
module sar_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     rd_rdy_i,
    output logic                     rd_vld_o,
    output logic [WIDTH-1:0]         rd_dat_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             full, pop, wr_en, drop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign pop   = rd_rdy_i & (cnt_q != '0);
    assign wr_en = wr_vld_i & (~full | pop);
    assign drop  = wr_vld_i & full & ~pop;

    // Pointer/count/head next state; the head register only moves when something will be stored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        ovf_d    = (ovf_q & ~ovf_clr_i) | drop;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (cnt_d != '0) begin
            // New head is the incoming word when it lands exactly at the new read slot.
            if (wr_en && (wr_ptr_q == rd_ptr_d)) dout_d = wr_dat_i;
            else                                  dout_d = mem_q[rd_ptr_d];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_vld_o   = (cnt_q != '0);
    assign rd_dat_o   = dout_q;
    assign level_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sar_capture_avg.sv
// Captures one SAR result per eoc high period, averages 1/2/4/8 samples, queues results.
// Latency: completing sample edge -> PUSH cycle -> dout_valid on the following cycle.
// Backpressure: results hitting a full FIFO without a same-cycle pop are dropped and flagged.
module sar_capture_avg
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   eoc,
    input  logic [WIDTH-1:0]       sar,
    input  logic [1:0]             avg_sel,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    state_t           state_q, state_d;
    logic             eoc_q;
    logic             sample;
    logic [WIDTH+2:0] acc_q, acc_d, sum;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       win_q, win_d, win_eff;
    logic [WIDTH-1:0] res_q, res_d;
    logic             push;

    assign sample = eoc & ~eoc_q;

    // Window accumulation and ACC/PUSH sequencing. The window closes by clearing acc/count
    // immediately, so a sample landing in the PUSH cycle naturally starts a fresh window.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        res_d   = res_q;
        push    = 1'b0;
        win_eff = (cnt_q == 3'd0) ? avg_sel : win_q;
        sum     = acc_q + {3'b000, sar};
        if (state_q == ST_PUSH) begin
            push    = 1'b1;
            state_d = ST_ACC;
        end
        if (sample) begin
            win_d = win_eff;
            if ((4'(cnt_q) + 4'd1) == win_len(win_eff)) begin
                state_d = ST_PUSH;
                res_d   = WIDTH'(sum >> win_eff);
                acc_d   = '0;
                cnt_d   = 3'd0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Edge detector, FSM state and window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            eoc_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= 3'd0;
            win_q   <= 2'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            res_q   <= res_d;
        end
    end

    sar_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_vld_i   (push),
        .wr_dat_i   (res_q),
        .rd_rdy_i   (dout_ready),
        .rd_vld_o   (dout_valid),
        .rd_dat_o   (dout),
        .level_o    (level),
        .overflow_o (overflow),
        .ovf_clr_i  (ovf_clr)
    );

endmodule

// File: tb/tb_sar_capture_avg.sv
// Directed bench for sar_capture_avg with a queue-based scoreboard on the output port.
// Stimulus drives 1ns after the rising edge; the monitor samples on the falling edge.
// Expected results are pushed by the stimulus and popped by the monitor on each transfer.
module tb_sar_capture_avg;

    logic       clk = 1'b0;
    logic       rst;
    logic       eoc;
    logic [9:0] sar;
    logic [1:0] avg_sel;
    logic [9:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    sar_capture_avg dut (
        .clk        (clk),
        .rst        (rst),
        .eoc        (eoc),
        .sar        (sar),
        .avg_sel    (avg_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // Scoreboard monitor: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            n_pop++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got dout=%h, expected no output", dout);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL dout_data: got %h, expected %h", dout, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One eoc high period of a single cycle, then two low cycles so any push completes.
    task automatic pulse(input logic [9:0] v);
        sar = v;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int p0;
        rst = 1'b1; eoc = 1'b0; sar = '0; avg_sel = 2'd0;
        dout_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);

        // Single-sample windows, consumer always ready.
        dout_ready = 1'b1;
        exp_q.push_back(10'h155); pulse(10'h155);
        exp_q.push_back(10'h2AA); pulse(10'h2AA);
        repeat (3) tick();
        chk("basic_pops", n_pop, 2);
        chk("basic_overflow", overflow, 0);

        // Four-sample window: 100+101+102+104 = 407, 407>>2 = 101.
        avg_sel = 2'd2;
        p0 = n_pop;
        pulse(10'd100); pulse(10'd101); pulse(10'd102);
        repeat (2) tick();
        chk("avg4_no_early_push", n_pop - p0, 0);
        exp_q.push_back(10'd101); pulse(10'd104);
        repeat (3) tick();
        chk("avg4_one_push", n_pop - p0, 1);

        // Window size latched at first sample: (10+20)>>1 = 15, then a single 7.
        avg_sel = 2'd1;
        pulse(10'd10);
        avg_sel = 2'd0;
        exp_q.push_back(10'd15); pulse(10'd20);
        exp_q.push_back(10'd7);  pulse(10'd7);
        repeat (3) tick();

        // Overflow: five results into a four-entry FIFO with no consumer; the fifth is dropped.
        dout_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(10'(i));
            pulse(10'(i));
        end
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", dout, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        dout_ready = 1'b1;
        repeat (6) tick();
        dout_ready = 1'b0;
        chk("ovf_drained", level, 0);

        // Full FIFO with a pop in the same cycle as the push: push accepted, level holds.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(10'(10 + i));
            pulse(10'(10 + i));
        end
        chk("full_level", level, 4);
        exp_q.push_back(10'd14);
        sar = 10'd14;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        tick();
        chk("popfull_level", level, 4);
        chk("popfull_overflow", overflow, 0);
        dout_ready = 1'b1;
        repeat (6) tick();
        chk("popfull_drained", level, 0);

        // Reset mid-window discards the partial sum of three samples.
        avg_sel = 2'd3;
        pulse(10'h100); pulse(10'h100); pulse(10'h100);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("midrst_dout", dout, 0);
        chk("midrst_level", level, 0);
        p0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(10'h3FF);
            pulse(10'h3FF);
        end
        repeat (3) tick();
        chk("avg8_one_push", n_pop - p0, 1);

        // Long eoc high period yields exactly one sample.
        avg_sel = 2'd0;
        p0 = n_pop;
        exp_q.push_back(10'h0F0);
        sar = 10'h0F0;
        eoc = 1'b1;
        repeat (20) tick();
        eoc = 1'b0;
        repeat (5) tick();
        chk("long_eoc_pushes", n_pop - p0, 1);
        chk("long_eoc_dout", dout, 10'h0F0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
